// File: rtl/mem_access_ctrl.sv
// MAR/MDR access sequencer shared by fetch (0) and execute (1) units.
// Round-robin grant, one access in flight, Moore strobes registered from next state.
module mem_access_ctrl #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int WAIT_CYC = 0
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic [1:0]      req,
    input  logic [1:0]      wr,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic [AW-1:0]   mar_addr,
    output logic            nLm,
    output logic            nLw,
    output logic            nLr,
    output logic            Em,
    output logic            ram_we,
    output logic [DW-1:0]   bus_out,
    output logic            bus_oe,
    input  logic [DW-1:0]   bus_in
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, MRD, MOUT, WLD, WMEM, DONE} state_t;

    localparam logic [3:0] WAIT_LD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t     state, state_n;
    logic       sel, sel_n;
    logic       op, op_n;
    logic       last;
    logic       arb;
    logic [3:0] cnt, cnt_n;

    // Tie goes to whoever was not granted last.
    always_comb begin
        arb = (req == 2'b11) ? ~last : req[1];
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        op_n    = op;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    sel_n   = arb;
                    op_n    = wr[arb];
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (WAIT_CYC > 0) begin
                    cnt_n   = WAIT_LD;
                    state_n = WAIT;
                end else begin
                    state_n = op ? WLD : MRD;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_n = op ? WLD : MRD;
                else             cnt_n   = cnt - 4'd1;
            end
            MRD:     state_n = MOUT;
            MOUT:    state_n = DONE;
            WLD:     state_n = WMEM;
            WMEM:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= IDLE;
            sel      <= 1'b0;
            op       <= 1'b0;
            cnt      <= 4'd0;
            last     <= 1'b1;
            done     <= 2'b00;
            rdata    <= '0;
            busy     <= 1'b0;
            mar_addr <= '0;
            bus_out  <= '0;
            nLm      <= 1'b1;
            nLw      <= 1'b1;
            nLr      <= 1'b1;
            Em       <= 1'b0;
            ram_we   <= 1'b0;
            bus_oe   <= 1'b0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            op    <= op_n;
            cnt   <= cnt_n;
            if (state == IDLE && |req) last <= sel_n;
            if (state == MOUT) rdata <= bus_in;
            busy     <= (state_n != IDLE);
            mar_addr <= (state_n == IDLE) ? '0 : (sel_n ? addr[2*AW-1:AW] : addr[AW-1:0]);
            bus_out  <= (state_n == IDLE) ? '0 : (sel_n ? wdata[2*DW-1:DW] : wdata[DW-1:0]);
            nLm      <= (state_n != ADDR);
            nLw      <= (state_n != WLD);
            nLr      <= (state_n != MRD);
            Em       <= (state_n == MOUT);
            ram_we   <= (state_n == WMEM);
            bus_oe   <= (state_n == WLD);
            done     <= (state_n == DONE) ? (sel_n ? 2'b10 : 2'b01) : 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: MAR/MDR/RAM model on u0 (no wait states), timing-only on u1 (3 wait states).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    always #5 clk = ~clk;

    // u0 signals
    logic [1:0]  req, wr;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  done;
    logic [7:0]  rdata, bus_out, wbus;
    logic        busy, nlm, nlw, nlr, em, ram_we, bus_oe;
    logic [15:0] mar_addr;

    // u1 signals
    logic [1:0]  r1_req, r1_done;
    logic [31:0] r1_addr;
    logic [7:0]  r1_rdata, r1_bus_out, r1_bus_in;
    logic        r1_busy, r1_nlm, r1_nlw, r1_nlr, r1_em, r1_ram_we, r1_bus_oe;
    logic [15:0] r1_mar;

    // memory datapath model for u0
    logic [7:0]  ram [0:255];
    logic [15:0] mar;
    logic [7:0]  mdr;
    logic        pre_we;
    logic [7:0]  pre_a, pre_d;

    assign wbus      = bus_oe ? bus_out : (em ? mdr : 8'h00);
    assign r1_bus_in = r1_em ? 8'hC3 : 8'h00;

    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        if (!nlm) mar <= mar_addr;
        if (!nlr) mdr <= ram[mar[7:0]];
        else if (!nlw) mdr <= wbus;
        if (ram_we) ram[mar[7:0]] <= mdr;
    end

    mem_access_ctrl #(.AW(16), .DW(8), .WAIT_CYC(0)) u0 (
        .CLK(clk), .CLR(clr), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .busy(busy), .mar_addr(mar_addr),
        .nLm(nlm), .nLw(nlw), .nLr(nlr), .Em(em), .ram_we(ram_we),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(wbus)
    );

    mem_access_ctrl #(.AW(16), .DW(8), .WAIT_CYC(3)) u1 (
        .CLK(clk), .CLR(clr), .req(r1_req), .wr(2'b00), .addr(r1_addr), .wdata(16'h0000),
        .done(r1_done), .rdata(r1_rdata), .busy(r1_busy), .mar_addr(r1_mar),
        .nLm(r1_nlm), .nLw(r1_nlw), .nLr(r1_nlr), .Em(r1_em), .ram_we(r1_ram_we),
        .bus_out(r1_bus_out), .bus_oe(r1_bus_oe), .bus_in(r1_bus_in)
    );

    typedef struct {
        logic [1:0] done;
        logic       is_rd;
        logic [7:0] rdata;
    } exp_t;
    exp_t sbq[$];

    int pass_cnt = 0;
    int total    = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!clr) check("excl", {30'd0, em & bus_oe, ~nlw & ~nlr}, 32'd0);
    endtask

    task automatic push(input logic [1:0] d, input logic rd, input logic [7:0] v);
        exp_t e;
        e.done = d; e.is_rd = rd; e.rdata = v;
        sbq.push_back(e);
    endtask

    task automatic sb_pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, {31'd0, sbq.size() > 0}, 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, "_done"}, {30'd0, done}, {30'd0, e.done});
            if (e.is_rd) check({tag, "_rdata"}, {24'd0, rdata}, {24'd0, e.rdata});
        end
    endtask

    task automatic finish_access(input string tag, input int lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (done == 2'b00 && n < 40);
        check({tag, "_latency"}, n, lat);
        sb_pop_check(tag);
    endtask

    initial begin
        clr = 1'b1; req = 2'b00; wr = 2'b00; addr = '0; wdata = '0;
        r1_req = 2'b00; r1_addr = {16'h0000, 16'h0044};
        pre_we = 1'b1; pre_a = 8'h10; pre_d = 8'h3C;
        tick();
        pre_a = 8'h30; pre_d = 8'h5A;
        tick();
        pre_we = 1'b0;
        clr = 1'b0;
        tick();

        // reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_mar", {16'd0, mar_addr}, 32'd0);
        check("rst_strobes", {26'd0, nlm, nlw, nlr, em, ram_we, bus_oe}, 32'b111000);
        check("rst_bus_out", {24'd0, bus_out}, 32'd0);
        check("rst_u1_busy", {31'd0, r1_busy}, 32'd0);

        // T2 single read
        req = 2'b01; wr = 2'b00; addr = {16'h0030, 16'h0010};
        push(2'b01, 1'b1, 8'h3C);
        tick();
        check("t2_c1_nlm", {31'd0, nlm}, 32'd0);
        check("t2_c1_mar", {16'd0, mar_addr}, 32'h0010);
        check("t2_c1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t2_c2_nlr_em", {30'd0, nlr, em}, 32'b00);
        tick();
        check("t2_c3_em_nlr", {30'd0, em, nlr}, 32'b11);
        tick();
        sb_pop_check("t2");
        req = 2'b00;
        tick();
        check("t2_idle_busy", {31'd0, busy}, 32'd0);
        check("t2_idle_done", {30'd0, done}, 32'd0);

        // T3 single write, then read back
        req = 2'b10; wr = 2'b10; addr = {16'h0020, 16'h0010}; wdata = {8'hA5, 8'h00};
        push(2'b10, 1'b0, 8'h00);
        tick();
        check("t3_addr_nlm", {31'd0, nlm}, 32'd0);
        check("t3_addr_mar", {16'd0, mar_addr}, 32'h0020);
        tick();
        check("t3_wld_strobes", {28'd0, bus_oe, nlw, em, nlr}, 32'b1001);
        check("t3_wld_bus_out", {24'd0, bus_out}, 32'hA5);
        tick();
        check("t3_wmem_strobes", {29'd0, ram_we, bus_oe, nlw}, 32'b101);
        tick();
        sb_pop_check("t3");
        check("t3_rdata_held", {24'd0, rdata}, 32'h3C);
        req = 2'b00; wr = 2'b00;
        tick();
        req = 2'b01; addr = {16'h0030, 16'h0020};
        push(2'b01, 1'b1, 8'hA5);
        finish_access("t3_rb", 4);
        req = 2'b00;
        tick();

        // T4 tie arbitration from reset
        clr = 1'b1; req = 2'b11; wr = 2'b00; addr = {16'h0030, 16'h0010};
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, (i % 2 == 0) ? 8'h3C : 8'h5A);
            finish_access("t4", (i == 0) ? 4 : 5);
        end
        req = 2'b00;
        tick();

        // T1 reset mid-access, in MRD
        req = 2'b01; addr = {16'h0030, 16'h0010};
        tick();
        tick();
        check("t1_in_mrd", {31'd0, nlr}, 32'd0);
        clr = 1'b1; req = 2'b00;
        tick();
        clr = 1'b0;
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_nlr_em", {30'd0, nlr, em}, 32'b10);
        check("t1_done", {30'd0, done}, 32'd0);
        check("t1_rdata", {24'd0, rdata}, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done != 2'b00) seen = 1'b1;
            end
            check("t1_no_done", {31'd0, seen}, 32'd0);
        end

        // T6 withdrawn request
        req = 2'b01; addr = {16'h0010, 16'h0030};
        push(2'b01, 1'b1, 8'h5A);
        tick();
        req = 2'b00;
        finish_access("t6", 3);
        tick();
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        check("t6_idle_done", {30'd0, done}, 32'd0);

        // T5 wait states on u1
        r1_req = 2'b01;
        tick();
        check("t5_addr_nlm", {31'd0, r1_nlm}, 32'd0);
        check("t5_addr_mar", {16'd0, r1_mar}, 32'h0044);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_wait_strobes", {25'd0, r1_busy, r1_nlm, r1_nlw, r1_nlr, r1_em, r1_ram_we, r1_bus_oe},
                  32'b1111000);
        end
        tick();
        check("t5_mrd_nlr", {31'd0, r1_nlr}, 32'd0);
        check("t5_mrd_done", {30'd0, r1_done}, 32'd0);
        tick();
        check("t5_mout_em", {31'd0, r1_em}, 32'd1);
        check("t5_mout_done", {30'd0, r1_done}, 32'd0);
        tick();
        check("t5_done", {30'd0, r1_done}, 32'b01);
        check("t5_rdata", {24'd0, r1_rdata}, 32'hC3);
        r1_req = 2'b00;
        tick();
        check("t5_idle_busy", {31'd0, r1_busy}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
